pipeline_dump_tx: RTL

- Debug reader for the pipeline's observation ports: on a start request, snapshots PC, register file and data memory.
- Serializes the snapshot as a fixed byte frame over a valid/ready byte stream to the UART transmitter.
- Sits between the pipeline debug outputs and the host link, so the pipeline keeps running while a frame drains.

---
 rtl/pipeline_dump_tx_if.sv | 14 +
 rtl/pipeline_dump_tx.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_dump_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_dump_tx_if : byte stream (valid/ready) from dump reader to UART  |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface pipeline_dump_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/pipeline_dump_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_dump_tx : snapshots PC/regs/mem and streams them as a byte frame |
// | rev 1.0 ; define DUMP_CHECKSUM_EN to append an XOR checksum byte          |
// +--------------------------------------------------------------------------+
module pipeline_dump_tx #(
  parameter int         NREGS  = 32,
  parameter int         NMEM   = 10,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  wire                     clk_i,
  input  wire                     reset_ni,
  input  wire                     start_i,
  input  wire  [9:0]              pc_in_i,
  input  wire  [NREGS*32-1:0]     regs_in_i,
  input  wire  [NMEM*32-1:0]      mem_in_i,
  pipeline_dump_tx_if.master      tx_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int MAXN = (NREGS > NMEM) ? NREGS : NMEM;
  localparam int CW   = $clog2(MAXN * 4);
  localparam int WW   = CW - 2;
  localparam logic [CW-1:0] REG_LAST = CW'(NREGS * 4 - 1);
  localparam logic [CW-1:0] MEM_LAST = CW'(NMEM * 4 - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PCH  = 3'd2;
  localparam logic [2:0] S_PCL  = 3'd3;
  localparam logic [2:0] S_REG  = 3'd4;
  localparam logic [2:0] S_MEM  = 3'd5;
`ifdef DUMP_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd6;
`endif
  localparam logic [2:0] S_FIN  = 3'd7;

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [9:0]          pc_q;
  logic [NREGS*32-1:0] regs_q;
  logic [NMEM*32-1:0]  mem_q;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  logic        w_capture;
  logic        w_active;
  logic        w_xfer;
  logic [31:0] w_word;
  logic [7:0]  w_byte;

  assign w_capture = (state_q == S_IDLE) && start_i;
  assign w_active  = (state_q != S_IDLE) && (state_q != S_FIN);
  assign w_xfer    = w_active && tx_o.tx_ready;

  // Word selected by the upper counter bits from whichever shadow is being sent.
  always_comb begin
    w_word = 32'h0;
    if (state_q == S_MEM) begin
      for (int i = 0; i < NMEM; i++)
        if (cnt_q[CW-1:2] == WW'(i)) w_word = mem_q[32*i +: 32];
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (cnt_q[CW-1:2] == WW'(i)) w_word = regs_q[32*i +: 32];
    end
  end

  always_comb begin
    w_byte = 8'h00;
    case (state_q)
      S_HDR: w_byte = HEADER;
      S_PCH: w_byte = {6'b0, pc_q[9:8]};
      S_PCL: w_byte = pc_q[7:0];
      S_REG, S_MEM: begin
        case (cnt_q[1:0])
          2'd0:    w_byte = w_word[31:24];
          2'd1:    w_byte = w_word[23:16];
          2'd2:    w_byte = w_word[15:8];
          default: w_byte = w_word[7:0];
        endcase
      end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM: w_byte = csum_q;
`endif
      default: w_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_HDR;
      S_HDR:  if (w_xfer)  state_d = S_PCH;
      S_PCH:  if (w_xfer)  state_d = S_PCL;
      S_PCL: if (w_xfer) begin
        state_d = S_REG;
        cnt_d   = '0;
      end
      S_REG: if (w_xfer) begin
        if (cnt_q == REG_LAST) begin
          state_d = S_MEM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MEM: if (w_xfer) begin
        if (cnt_q == MEM_LAST) begin
`ifdef DUMP_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_FIN;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM: if (w_xfer) state_d = S_FIN;
`endif
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Inputs are sampled only on an accepted start; the pipeline may run on freely.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_q   <= '0;
      regs_q <= '0;
      mem_q  <= '0;
    end else if (w_capture) begin
      pc_q   <= pc_in_i;
      regs_q <= regs_in_i;
      mem_q  <= mem_in_i;
    end
  end

`ifdef DUMP_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)      csum_q <= 8'h00;
    else if (w_capture) csum_q <= 8'h00;
    else if (w_xfer)    csum_q <= csum_q ^ w_byte;
  end
`endif

  assign tx_o.tx_data  = w_byte;
  assign tx_o.tx_valid = w_active;
  assign busy_o        = w_active;
  assign done_o        = (state_q == S_FIN);

endmodule
`default_nettype wire
